pe_config_loader: RTL and testbench

Configuration front-end for the PE array. It accepts configuration packets from the host or configuration memory as a valid/ready word stream and buffers each packet completely. It then bursts the packet, one word per cycle with no gaps, onto the 33-bit `PE_Configure_Inport` of the addressed `PE_top` instance. It sits directly upstream of every `PE_top` configure port and guarantees the contiguous header-then-data word sequence each PE expects, regardless of bubbles in the source stream.

---
 rtl/pe_config_loader.sv | 137 +++++++++++++
 tb/tb_pe_config_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_config_loader.sv
// Configuration front-end for the PE array.
// Collects one configuration packet from a valid/ready word stream into a
// local buffer, then replays it without gaps onto the configure port of the
// addressed PE. Packets that overflow the buffer or name a nonexistent PE
// are rejected with a one-cycle error pulse and never reach any PE.
`timescale 1ns/1ps

module pe_config_loader #(
    parameter int NUM_PE  = 4,
    parameter int PE_ID_W = 2,
    parameter int DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_in_valid,
    output logic                  cfg_in_ready,
    input  logic [31:0]           cfg_in_data,
    input  logic                  cfg_in_last,
    input  logic [PE_ID_W-1:0]    cfg_in_pe_id,
    output logic [NUM_PE*33-1:0]  PE_Configure_Outport,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic                  cfg_busy
);

    // Count runs 0..DEPTH inclusive, so it needs one more code than an index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        BURST   = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       ptr_q;
    logic [PE_ID_W-1:0]     tgt_q;
    logic [NUM_PE*33-1:0]   outPort_q;
    logic                   done_q;
    logic                   err_q;
    logic [31:0]            wordBuf_q [DEPTH];

    logic                   accept;
    logic                   isFull;
    logic [PE_ID_W-1:0]     idEff;
    logic                   idOk;
    logic [31:0]            rdWord;

    // Ready is held low while reset is asserted so no beat slips in during it.
    assign cfg_in_ready = ((state_q == COLLECT) || (state_q == DRAIN)) && !reset;
    assign accept       = cfg_in_valid && cfg_in_ready;
    assign isFull       = (count_q == CNT_W'(DEPTH));

    // The target comes straight off the bus on the first beat, afterwards
    // from the latched copy.
    assign idEff  = (count_q == '0) ? cfg_in_pe_id : tgt_q;
    assign idOk   = (32'(idEff) < NUM_PE);
    assign rdWord = wordBuf_q[ptr_q[IDX_W-1:0]];

    assign PE_Configure_Outport = outPort_q;
    assign cfg_done             = done_q;
    assign cfg_err              = err_q;
    assign cfg_busy             = (state_q != COLLECT);

    // Packet storage: plain RAM-style array with no reset, written while collecting.
    always_ff @(posedge clk) begin
        if (accept && (state_q == COLLECT) && !isFull) begin
            wordBuf_q[count_q[IDX_W-1:0]] <= cfg_in_data;
        end
    end

    // Control FSM: collect, reject/drain, or replay the buffered packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            len_q     <= '0;
            ptr_q     <= '0;
            tgt_q     <= '0;
            outPort_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (isFull || !idOk) begin
                            // Rejected packet: nothing is emitted; skip the
                            // rest of it unless this beat already ended it.
                            err_q   <= 1'b1;
                            count_q <= '0;
                            state_q <= cfg_in_last ? COLLECT : DRAIN;
                        end else begin
                            if (count_q == '0) begin
                                tgt_q <= cfg_in_pe_id;
                            end
                            count_q <= count_q + 1'b1;
                            if (cfg_in_last) begin
                                len_q   <= count_q + 1'b1;
                                ptr_q   <= '0;
                                state_q <= BURST;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept && cfg_in_last) begin
                        count_q <= '0;
                        state_q <= COLLECT;
                    end
                end
                BURST: begin
                    if (ptr_q == len_q) begin
                        outPort_q <= '0;
                        done_q    <= 1'b1;
                        count_q   <= '0;
                        state_q   <= COLLECT;
                    end else begin
                        for (int i = 0; i < NUM_PE; i++) begin
                            outPort_q[33*i +: 33] <= (tgt_q == PE_ID_W'(i)) ? {1'b1, rdWord} : 33'd0;
                        end
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// Self-checking bench for pe_config_loader.
// A 4-PE instance carries most traffic; a 3-PE instance exercises the
// out-of-range target rejection. Expected slice words go into a scoreboard
// queue when a packet is driven and are popped by a monitor as they appear.
`timescale 1ns/1ps

module tb_pe_config_loader;

    typedef struct {
        int          sel;
        int          slice;
        logic [32:0] word;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          valid0;
    logic          valid3;
    logic [31:0]   data;
    logic          last;
    logic [1:0]    peId;

    logic          ready0;
    logic [131:0]  out0;
    logic          done0;
    logic          err0;
    logic          busy0;

    logic          ready3;
    logic [98:0]   out3;
    logic          done3;
    logic          err3;
    logic          busy3;

    exp_t          sb [$];
    logic [31:0]   pkt [32];
    int            checkCount;
    int            passCount;
    int            doneCnt0;
    int            errCnt0;
    int            doneCnt3;
    int            errCnt3;

    pe_config_loader #(.NUM_PE(4), .PE_ID_W(2), .DEPTH(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cfg_in_valid         (valid0),
        .cfg_in_ready         (ready0),
        .cfg_in_data          (data),
        .cfg_in_last          (last),
        .cfg_in_pe_id         (peId),
        .PE_Configure_Outport (out0),
        .cfg_done             (done0),
        .cfg_err              (err0),
        .cfg_busy             (busy0)
    );

    pe_config_loader #(.NUM_PE(3), .PE_ID_W(2), .DEPTH(16)) dut3 (
        .clk                  (clk),
        .reset                (reset),
        .cfg_in_valid         (valid3),
        .cfg_in_ready         (ready3),
        .cfg_in_data          (data),
        .cfg_in_last          (last),
        .cfg_in_pe_id         (peId),
        .PE_Configure_Outport (out3),
        .cfg_done             (done3),
        .cfg_err              (err3),
        .cfg_busy             (busy3)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic portNz(input int sel);
        return (sel == 0) ? (out0 != '0) : (out3 != '0);
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ready0 : ready3;
    endfunction

    // Compare whatever slice is active against the head of the scoreboard.
    task automatic scanPort(input int sel, input logic [131:0] port);
        int   nz;
        int   idx;
        exp_t e;
        nz  = 0;
        idx = 0;
        for (int s = 0; s < 4; s++) begin
            if (port[33*s +: 33] != 33'd0) begin
                nz++;
                idx = s;
            end
        end
        if (nz != 0) begin
            checkOutput("oneSliceActive", 64'(nz), 64'd1);
            if (sb.size() == 0) begin
                checkOutput("unexpectedSlice", 64'(port[33*idx +: 33]), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sliceDut", 64'(sel), 64'(e.sel));
                checkOutput("sliceIndex", 64'(idx), 64'(e.slice));
                checkOutput("sliceWord", 64'(port[33*idx +: 33]), 64'(e.word));
            end
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        scanPort(0, out0);
        scanPort(1, {33'd0, out3});
        if (done0) doneCnt0++;
        if (err0)  errCnt0++;
        if (done3) doneCnt3++;
        if (err3)  errCnt3++;
    end

    // Drive one beat (entered at a falling edge) and return at the falling
    // edge after the accepting rising edge; valid is left high.
    task automatic applyStimulus(input int sel, input logic [31:0] word, input logic isLast, input logic [1:0] id);
        int guard;
        guard = 0;
        data  = word;
        last  = isLast;
        peId  = id;
        if (sel == 0) valid0 = 1'b1;
        else          valid3 = 1'b1;
        while (!rdy(sel) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checkOutput("readyTimeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        valid0 = 1'b0;
        valid3 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Send pkt[0..n-1]; valid packets queue their expected slice words first.
    task automatic sendPacket(input int sel, input logic [1:0] id, input int n, input int bubbles, input bit good);
        if (good) begin
            for (int i = 0; i < n; i++) sb.push_back('{sel, int'(id), {1'b1, pkt[i]}});
        end
        for (int i = 0; i < n; i++) begin
            applyStimulus(sel, pkt[i], (i == n - 1), id);
            if (i < n - 1 && bubbles > 0) idle(bubbles);
        end
    endtask

    // Entered at the falling edge after the last beat's edge T: check the
    // burst occupies exactly the n cycles after T+1..T+n, then completes.
    task automatic checkBurst(input int sel, input int n);
        #1;
        checkOutput("queuedAtLast", 64'(sb.size()), 64'(n));
        checkOutput("quietBeforeBurst", 64'(portNz(sel)), 64'd0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk); #1;
            checkOutput("busyInBurst", 64'(sel == 0 ? busy0 : busy3), 64'd1);
            checkOutput("readyLowInBurst", 64'(rdy(sel)), 64'd0);
            checkOutput("doneNotEarly", 64'(sel == 0 ? done0 : done3), 64'd0);
        end
        @(negedge clk); #1;
        checkOutput("doneAfterBurst", 64'(sel == 0 ? done0 : done3), 64'd1);
        checkOutput("sliceClearAfter", 64'(portNz(sel)), 64'd0);
        checkOutput("readyBack", 64'(rdy(sel)), 64'd1);
        checkOutput("queueDrained", 64'(sb.size()), 64'd0);
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: observed running expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    // Directed sequence of test steps.
    initial begin
        checkCount = 0;
        passCount  = 0;
        doneCnt0   = 0;
        errCnt0    = 0;
        doneCnt3   = 0;
        errCnt3    = 0;
        reset  = 1'b1;
        valid0 = 1'b0;
        valid3 = 1'b0;
        data   = '0;
        last   = 1'b0;
        peId   = '0;

        #1;
        checkOutput("rstOut", 64'(portNz(0)), 64'd0);
        checkOutput("rstReady", 64'(ready0), 64'd0);
        checkOutput("rstDone", 64'(done0), 64'd0);
        checkOutput("rstErr", 64'(err0), 64'd0);
        checkOutput("rstBusy", 64'(busy0), 64'd0);
        checkOutput("rstReady3", 64'(ready3), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("readyAfterRst", 64'(ready0), 64'd1);
        checkOutput("readyAfterRst3", 64'(ready3), 64'd1);

        // Three words to PE0 with two idle cycles between beats.
        pkt[0] = 32'h4B29_2108; pkt[1] = 32'd0; pkt[2] = 32'd100;
        sendPacket(0, 2'd0, 3, 2, 1'b1);
        idle(0);
        checkBurst(0, 3);
        checkOutput("doneCountPe0", 64'(doneCnt0), 64'd1);

        // Two words to PE1.
        pkt[0] = 32'h4B29_2108; pkt[1] = 32'd1;
        sendPacket(0, 2'd1, 2, 0, 1'b1);
        idle(0);
        checkBurst(0, 2);
        checkOutput("doneCountPe1", 64'(doneCnt0), 64'd2);

        // Overflow: seventeen non-last words to PE2, then a last word.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 32'hA000_0000 + 32'(i), 1'b0, 2'd2);
            #1;
            if (i == 15) checkOutput("noErrAtFull", 64'(err0), 64'd0);
        end
        checkOutput("errOnOverflow", 64'(err0), 64'd1);
        checkOutput("busyInDrain", 64'(busy0), 64'd1);
        checkOutput("readyInDrain", 64'(ready0), 64'd1);
        applyStimulus(0, 32'hA0FF_FFFF, 1'b1, 2'd2);
        idle(0);
        #1;
        checkOutput("drainExit", 64'(busy0), 64'd0);
        checkOutput("errPulseOnce", 64'(errCnt0), 64'd1);
        checkOutput("noDoneOnOverflow", 64'(doneCnt0), 64'd2);

        // Out-of-range target on the 3-PE instance.
        applyStimulus(1, 32'hCAFE_0001, 1'b1, 2'd3);
        #1;
        checkOutput("errBadTarget", 64'(err3), 64'd1);
        checkOutput("stayCollect", 64'(busy3), 64'd0);
        applyStimulus(1, 32'hCAFE_0002, 1'b0, 2'd3);
        #1;
        checkOutput("errBadTargetMulti", 64'(err3), 64'd1);
        checkOutput("drainBadTarget", 64'(busy3), 64'd1);
        applyStimulus(1, 32'hCAFE_0003, 1'b1, 2'd0);
        idle(0);
        #1;
        checkOutput("drainExit3", 64'(busy3), 64'd0);
        checkOutput("errCount3", 64'(errCnt3), 64'd2);
        pkt[0] = 32'h1111_1111; pkt[1] = 32'h2222_2222;
        sendPacket(1, 2'd2, 2, 0, 1'b1);
        idle(0);
        checkBurst(1, 2);
        checkOutput("doneCount3", 64'(doneCnt3), 64'd1);

        // Back-to-back packets with valid held high: PE0 then PE3.
        pkt[0] = 32'h0000_0A00; pkt[1] = 32'h0000_0A01; pkt[2] = 32'h0000_0A02; pkt[3] = 32'h0000_0A03;
        sendPacket(0, 2'd0, 4, 0, 1'b1);
        data = 32'h0000_0B00; last = 1'b0; peId = 2'd3; valid0 = 1'b1;
        checkBurst(0, 4);
        pkt[0] = 32'h0000_0B00; pkt[1] = 32'h0000_0B01; pkt[2] = 32'h0000_0B02; pkt[3] = 32'h0000_0B03;
        sendPacket(0, 2'd3, 4, 0, 1'b1);
        idle(0);
        checkBurst(0, 4);
        checkOutput("doneCountB2B", 64'(doneCnt0), 64'd4);

        // Reset while the second word of a four-word burst is on the slice.
        pkt[0] = 32'h0000_0C00; pkt[1] = 32'h0000_0C01; pkt[2] = 32'h0000_0C02; pkt[3] = 32'h0000_0C03;
        sendPacket(0, 2'd1, 4, 0, 1'b1);
        idle(0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstMidBurstOut", 64'(portNz(0)), 64'd0);
        checkOutput("rstMidBurstReady", 64'(ready0), 64'd0);
        checkOutput("rstMidBurstQueue", 64'(sb.size()), 64'd2);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("readyAfterMidRst", 64'(ready0), 64'd1);
        checkOutput("noDoneOnReset", 64'(doneCnt0), 64'd4);
        pkt[0] = 32'h0000_0D00; pkt[1] = 32'h0000_0D01; pkt[2] = 32'h0000_0D02;
        sendPacket(0, 2'd3, 3, 1, 1'b1);
        idle(0);
        checkBurst(0, 3);
        checkOutput("doneCountFinal", 64'(doneCnt0), 64'd5);
        checkOutput("errCountFinal", 64'(errCnt0), 64'd1);

        idle(3);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
